lut_config_loader: RTL and testbench
====================================

// Module: lut_config_loader
// PURPOSE
//  Configuration controller for the fabric's 3-input LUT array: accepts a byte-wide
//  configuration stream over valid/ready, assembles NUM_LUTS 8-bit truth-table masks in
//  shadow registers, and commits them atomically to the active mask bus driving every LUT.
//  The LUTs never see a partial configuration. Sits between the bitstream source and the LUT array.
// PARAMETERS
//  NUM_LUTS   16      number of LUTs configured; one mask byte per LUT
//  SYNC_WORD  8'hA5   byte that opens a configuration frame
// PORTS
//  clk           in   1            single clock, all logic rising-edge
//  rst           in   1            synchronous, active-high reset
//  cfg_valid     in   1            cfg_data holds a byte
//  cfg_ready     out  1            loader accepts the byte this cycle (transfer = valid & ready)
//  cfg_data      in   8            stream byte
//  cfg_abort     in   1            discard the frame in progress
//  masks         out  NUM_LUTS*8   active masks; masks[i*8 +: 8] is the mask of LUT i
//  config_valid  out  1            high once any frame has committed; stays high
//  busy          out  1            frame in progress (state != IDLE)
//  cfg_done      out  1            one-cycle pulse on commit
//  cfg_error     out  1            one-cycle pulse on a rejected frame (checksum build only)
// BEHAVIOUR
//  - Reset: masks=0, config_valid=0, busy=0, cfg_done=0, cfg_error=0, cfg_ready=1, state=IDLE,
//    shadow and index cleared. Reset during a frame discards it; active masks return to 0.
//  - IDLE: cfg_ready=1. A transferred byte == SYNC_WORD -> LOAD, index=0. Any other byte is
//    consumed and dropped with no error.
//  - LOAD: cfg_ready=1. Each transfer writes shadow[index], then index++. The first byte
//    after sync goes to LUT 0. After byte NUM_LUTS-1, go to CHECK (checksum build) or COMMIT.
//    SYNC_WORD has no special meaning inside LUT, i.e. 0xA5 is a legal mask.
//  - COMMIT: one cycle, cfg_ready=0. Copy shadow to masks, set config_valid, pulse cfg_done
//    in the same cycle, then go to IDLE. masks change only in this cycle.
//  - Latency: the masks update and cfg_done rise on the clock after the last accepted byte
//    (the byte transferred from LOAD without the checksum, or from CHECK with it).
//  - Index counter width is $clog2(NUM_LUTS), with a minimum of 1 bit. Compare against
//    NUM_LUTS-1; the counter never wraps.
//  - cfg_abort in LOAD/CHECK: go to IDLE next cycle. The shadow is discarded, masks are
//    unchanged, and neither done nor error pulses. If a byte transfers in the same cycle, it
//    is consumed and dropped (abort wins). Abort in IDLE or COMMIT is ignored; a commit always
//    completes.
//  - No cfg_valid during LOAD: wait indefinitely with no timeout.
//  - cfg_done and cfg_error are never high in the same cycle.
// CONFIGURATION
//  Macro LUT_CFG_CHECKSUM_EN.
//  - Defined: a frame carries one extra trailing byte, equal to the XOR of all NUM_LUTS mask
//    bytes. State CHECK (cfg_ready=1) accepts this byte. On a match go to COMMIT. On a
//    mismatch, pulse cfg_error for one cycle in the cycle after the transfer and go to IDLE;
//    masks and config_valid are unchanged. A running XOR is kept during LOAD.
//  - Undefined: there is no CHECK state and no trailing byte. cfg_error is tied to 0.
// STRUCTURE
//  - Package lut_cfg_pkg contains:
//    - typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} lut_cfg_state_t
//    - localparam MASK_W = 8 (the LUT mask width)
//    - default SYNC_WORD constant
//  - No sub-module: the shadow array, counter, XOR and FSM are small enough to stay inline
//    in lut_config_loader.
// TESTING
//  - Nominal frame: NUM_LUTS=4, send A5,01,02,03,04 back-to-back. Expect masks=32'h04030201,
//    cfg_done pulsing one cycle after byte 04, and config_valid=1.
//  - Junk and gaps: send 00,FF,A5 with idle cycles between the mask bytes. Expect junk to be
//    dropped, masks unchanged until commit, and cfg_ready low only in the COMMIT cycle.
//  - Abort: send A5,11,22, then cfg_abort together with 33. Expect busy=0 next cycle, masks
//    to hold the previous frame, and no done/error. A following full frame commits normally.
//  - Reset mid-frame: assert rst after A5,11. Expect all outputs at reset values and
//    config_valid=0. The next frame loads from LUT 0.
//  - Checksum (LUT_CFG_CHECKSUM_EN): A5,01,02,03,04,04 -> commit. A5,01,02,03,04,05 ->
//    cfg_error pulse with masks unchanged.
//  - Back-to-back frames with no gap: SYNC accepted on the cycle after COMMIT. Both frames
//    commit and cfg_done pulses twice.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT configuration loader.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } lut_cfg_state_t;

    localparam int          MASK_W            = 8;
    localparam logic [7:0]  DEFAULT_SYNC_WORD = 8'hA5;

endpackage

// File: rtl/lut_config_loader.sv
// Byte-stream loader that assembles LUT truth-table masks in a shadow bank and commits them atomically.
// Optional trailing XOR checksum byte enabled by defining LUT_CFG_CHECKSUM_EN.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int          NUM_LUTS  = 16,
    parameter logic [7:0]  SYNC_WORD = DEFAULT_SYNC_WORD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MASK_W-1:0]            cfg_data,
    input  logic                         cfg_abort,
    output logic [NUM_LUTS*MASK_W-1:0]   masks,
    output logic                         config_valid,
    output logic                         busy,
    output logic                         cfg_done,
    output logic                         cfg_error
);

    localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

    lut_cfg_state_t              state_r;
    lut_cfg_state_t              state_s;
    logic [IDX_W-1:0]            idx_r;
    logic [MASK_W-1:0]           shadow_r [NUM_LUTS];
    logic [NUM_LUTS*MASK_W-1:0]  masks_r;
    logic                        config_valid_r;
    logic                        busy_r;
    logic                        cfg_ready_r;
    logic                        cfg_done_r;
    logic                        xfer_s;
    logic                        last_s;
    logic                        wr_s;
    logic                        commit_s;
    logic                        err_s;
`ifdef LUT_CFG_CHECKSUM_EN
    logic [MASK_W-1:0]           xor_r;
    logic                        cfg_error_r;
`endif

    assign xfer_s = cfg_valid & cfg_ready_r;
    assign last_s = (idx_r == IDX_W'(NUM_LUTS - 1));

    // Next-state decode; abort takes priority over a byte arriving in the same cycle.
    always_comb begin
        state_s  = state_r;
        wr_s     = 1'b0;
        commit_s = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (xfer_s && (cfg_data == SYNC_WORD)) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    state_s = IDLE;
                end else if (xfer_s) begin
                    wr_s = 1'b1;
                    if (last_s) begin
`ifdef LUT_CFG_CHECKSUM_EN
                        state_s = CHECK;
`else
                        state_s = COMMIT;
`endif
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
`ifdef LUT_CFG_CHECKSUM_EN
            CHECK: begin
                if (cfg_abort) begin
                    state_s = IDLE;
                end else if (xfer_s) begin
                    if (cfg_data == xor_r) begin
                        state_s = COMMIT;
                    end else begin
                        err_s   = 1'b1;
                        state_s = IDLE;
                    end
                end else begin
                    state_s = CHECK;
                end
            end
`endif
            COMMIT: begin
                commit_s = 1'b1;
                state_s  = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and status flags, all registered from the decoded next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            busy_r         <= 1'b0;
            cfg_ready_r    <= 1'b1;
            cfg_done_r     <= 1'b0;
            config_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            cfg_ready_r <= (state_s != COMMIT);
            cfg_done_r  <= commit_s;
            if (commit_s) begin
                config_valid_r <= 1'b1;
            end
        end
    end

    // Shadow bank fill; the index restarts whenever the loader is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= '0;
            for (int i = 0; i < NUM_LUTS; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (state_r == IDLE) begin
            idx_r <= '0;
        end else if (wr_s) begin
            shadow_r[idx_r] <= cfg_data;
            if (!last_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    // Active masks move only on commit so the LUTs never see a partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            masks_r <= '0;
        end else if (commit_s) begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                masks_r[i*MASK_W +: MASK_W] <= shadow_r[i];
            end
        end
    end

`ifdef LUT_CFG_CHECKSUM_EN
    // Running XOR of the mask bytes and the registered checksum-failure pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_r       <= '0;
            cfg_error_r <= 1'b0;
        end else begin
            cfg_error_r <= err_s;
            if (state_r == IDLE) begin
                xor_r <= '0;
            end else if (wr_s) begin
                xor_r <= xor_r ^ cfg_data;
            end
        end
    end

    assign cfg_error = cfg_error_r;
`else
    assign cfg_error = 1'b0 & err_s;
`endif

    assign cfg_ready    = cfg_ready_r;
    assign busy         = busy_r;
    assign cfg_done     = cfg_done_r;
    assign config_valid = config_valid_r;
    assign masks        = masks_r;

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed self-checking bench for lut_config_loader with NUM_LUTS=4.
module tb_lut_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_data;
    logic        cfg_abort;
    logic [31:0] masks;
    logic        config_valid;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;

    int checks = 0;
    int errors = 0;

    lut_config_loader #(.NUM_LUTS(4), .SYNC_WORD(8'hA5)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_abort(cfg_abort), .masks(masks),
        .config_valid(config_valid), .busy(busy), .cfg_done(cfg_done),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until it transfers (bounded wait).
    task automatic send(input logic [7:0] b);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_data  = b;
        while (!cfg_ready && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h ready stayed low", b);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    // Sync, four mask bytes (LUT0 first) and, in the checksum build, the XOR byte.
    task automatic send_frame(input logic [31:0] m);
        send(8'hA5);
        send(m[7:0]);
        send(m[15:8]);
        send(m[23:16]);
        send(m[31:24]);
`ifdef LUT_CFG_CHECKSUM_EN
        send(m[7:0] ^ m[15:8] ^ m[23:16] ^ m[31:24]);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (masks !== 32'h0 || config_valid !== 1'b0 || busy !== 1'b0 ||
            cfg_done !== 1'b0 || cfg_error !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset masks=%h cv=%b busy=%b done=%b err=%b rdy=%b want 0,0,0,0,0,1",
                     masks, config_valid, busy, cfg_done, cfg_error, cfg_ready);
        end
    endtask

    task automatic test_nominal();
        send(8'hA5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_busy got=%b want=1", busy);
        end
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
`ifdef LUT_CFG_CHECKSUM_EN
        send(8'h04);
`endif
        checks++;
        if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || masks !== 32'h0) begin
            errors++;
            $display("FAIL nominal_commit_cycle rdy=%b done=%b masks=%h want 0,0,00000000",
                     cfg_ready, cfg_done, masks);
        end
        tick();
        checks++;
        if (masks !== 32'h04030201 || cfg_done !== 1'b1 || config_valid !== 1'b1 ||
            busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL nominal_commit masks=%h done=%b cv=%b busy=%b rdy=%b want 04030201,1,1,0,1",
                     masks, cfg_done, config_valid, busy, cfg_ready);
        end
        tick();
        checks++;
        if (cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done_pulse got=%b want=0", cfg_done);
        end
    endtask

    task automatic test_junk_gaps();
        send(8'h00);
        send(8'hFF);
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL junk_dropped busy=%b rdy=%b want 0,1", busy, cfg_ready);
        end
        send(8'hA5);
        send(8'h10);
        tick();
        tick();
        send(8'h20);
        tick();
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || masks !== 32'h04030201) begin
            errors++;
            $display("FAIL gap_wait busy=%b rdy=%b masks=%h want 1,1,04030201",
                     busy, cfg_ready, masks);
        end
        send(8'h30);
        send(8'h40);
`ifdef LUT_CFG_CHECKSUM_EN
        send(8'h40);
`endif
        checks++;
        if (cfg_ready !== 1'b0 || masks !== 32'h04030201) begin
            errors++;
            $display("FAIL gap_commit_cycle rdy=%b masks=%h want 0,04030201", cfg_ready, masks);
        end
        tick();
        checks++;
        if (masks !== 32'h40302010 || cfg_done !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_commit masks=%h done=%b rdy=%b want 40302010,1,1",
                     masks, cfg_done, cfg_ready);
        end
    endtask

    task automatic test_abort();
        send(8'hA5);
        send(8'h11);
        send(8'h22);
        cfg_valid = 1'b1;
        cfg_data  = 8'h33;
        cfg_abort = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || masks !== 32'h40302010 || cfg_done !== 1'b0 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL abort busy=%b masks=%h done=%b err=%b want 0,40302010,0,0",
                     busy, masks, cfg_done, cfg_error);
        end
        tick();
        checks++;
        if (cfg_done !== 1'b0 || cfg_error !== 1'b0 || masks !== 32'h40302010) begin
            errors++;
            $display("FAIL abort_after done=%b err=%b masks=%h want 0,0,40302010",
                     cfg_done, cfg_error, masks);
        end
        send_frame(32'h88776655);
        tick();
        checks++;
        if (masks !== 32'h88776655 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL abort_recover masks=%h done=%b want 88776655,1", masks, cfg_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        send(8'hA5);
        send(8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (masks !== 32'h0 || config_valid !== 1'b0 || busy !== 1'b0 ||
            cfg_done !== 1'b0 || cfg_error !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid masks=%h cv=%b busy=%b done=%b err=%b rdy=%b want 0,0,0,0,0,1",
                     masks, config_valid, busy, cfg_done, cfg_error, cfg_ready);
        end
        send_frame(32'h0D0C0B0A);
        tick();
        checks++;
        if (masks !== 32'h0D0C0B0A || config_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reload masks=%h cv=%b want 0d0c0b0a,1", masks, config_valid);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(32'h04030201);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_commit_ready got=%b want=0", cfg_ready);
        end
        tick();
        checks++;
        if (cfg_done !== 1'b1 || masks !== 32'h04030201 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first done=%b masks=%h rdy=%b want 1,04030201,1",
                     cfg_done, masks, cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sync busy=%b done=%b want 1,0", busy, cfg_done);
        end
        send(8'hF1);
        send(8'hF2);
        send(8'hF3);
        send(8'hF4);
`ifdef LUT_CFG_CHECKSUM_EN
        send(8'hF1 ^ 8'hF2 ^ 8'hF3 ^ 8'hF4);
`endif
        tick();
        checks++;
        if (cfg_done !== 1'b1 || masks !== 32'hF4F3F2F1) begin
            errors++;
            $display("FAIL b2b_second done=%b masks=%h want 1,f4f3f2f1", cfg_done, masks);
        end
    endtask

`ifdef LUT_CFG_CHECKSUM_EN
    task automatic test_checksum();
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'h05);
        checks++;
        if (cfg_error !== 1'b1 || cfg_done !== 1'b0 || busy !== 1'b0 || masks !== 32'hF4F3F2F1) begin
            errors++;
            $display("FAIL csum_bad err=%b done=%b busy=%b masks=%h want 1,0,0,f4f3f2f1",
                     cfg_error, cfg_done, busy, masks);
        end
        tick();
        checks++;
        if (cfg_error !== 1'b0 || masks !== 32'hF4F3F2F1 || config_valid !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad_after err=%b masks=%h cv=%b want 0,f4f3f2f1,1",
                     cfg_error, masks, config_valid);
        end
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'h04);
        tick();
        checks++;
        if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || masks !== 32'h04030201) begin
            errors++;
            $display("FAIL csum_good done=%b err=%b masks=%h want 1,0,04030201",
                     cfg_done, cfg_error, masks);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        cfg_abort = 1'b0;
        test_reset();
        test_nominal();
        test_junk_gaps();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef LUT_CFG_CHECKSUM_EN
        test_checksum();
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
